// File: rtl/multi_beat.sv
// rtl/multi_beat.sv - multi-channel beat/tick generator with a one-deep configuration port (optional MULTI_BEAT_SYNC_EN adds sync_in)
`timescale 1ns/1ps
module multi_beat #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BEAT_FREQ = 5,
  parameter int NCH       = 4,
  parameter int CW        = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
`ifdef MULTI_BEAT_SYNC_EN
  input  logic                                     sync_in,
`endif
  input  logic                                     cfg_valid,
  output logic                                     cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [CW-1:0]                            cfg_half,
  input  logic [1:0]                               cfg_mode,
  output logic [NCH-1:0]                           beat,
  output logic [NCH-1:0]                           tick
);

  localparam int              CHW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   DEF_HALF    = CW'(CLK_FREQ / 2 / BEAT_FREQ);
  localparam logic [1:0]      MODE_TOGGLE = 2'd0;
  localparam logic [1:0]      MODE_PULSE  = 2'd1;

  logic           pend_valid;
  logic [CHW-1:0] pend_ch;
  logic [CW-1:0]  pend_half;
  logic [1:0]     pend_mode;
  logic           accept;
  logic           sync;

  assign accept = cfg_valid && cfg_ready;

`ifdef MULTI_BEAT_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Handshake: capture one request, drop ready for the apply cycle, then reopen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b0;
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_half  <= '0;
      pend_mode  <= MODE_TOGGLE;
    end else begin
      cfg_ready  <= !accept;
      pend_valid <= accept;
      if (accept) begin
        pend_ch   <= cfg_ch;
        pend_half <= cfg_half;
        pend_mode <= cfg_mode;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] count;
    logic [CW-1:0] half;
    logic [1:0]    mode;
    logic          beat_r;
    logic          tick_r;
    logic [CW-1:0] lim_m1;
    logic          hit;

    // half of zero behaves as a limit of one, so lim_m1 never underflows
    assign lim_m1 = (half == '0) ? '0 : half - CW'(1);
    // out-of-range channel numbers can never equal g, so they apply nowhere
    assign hit    = pend_valid && (pend_ch == CHW'(g));
    assign beat[g] = beat_r;
    assign tick[g] = tick_r;

    // Per-channel counter: apply has priority, then off/sync zeroing, then free-run with >= wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count  <= '0;
        half   <= DEF_HALF;
        mode   <= MODE_TOGGLE;
        beat_r <= 1'b0;
        tick_r <= 1'b0;
      end else if (hit) begin
        count  <= '0;
        half   <= pend_half;
        mode   <= pend_mode;
        beat_r <= 1'b0;
        tick_r <= 1'b0;
      end else if (mode[1] || sync) begin
        count  <= '0;
        beat_r <= 1'b0;
        tick_r <= 1'b0;
      end else if (count >= lim_m1) begin
        count  <= '0;
        tick_r <= 1'b1;
        beat_r <= (mode == MODE_PULSE) ? 1'b1 : ~beat_r;
      end else begin
        count  <= count + CW'(1);
        tick_r <= 1'b0;
        beat_r <= (mode == MODE_PULSE) ? 1'b0 : beat_r;
      end
    end
  end

endmodule
